// File: rtl/spike_gen_array_if.sv
// -----------------------------------------------------------------------------
// spike_gen_array_if
// Purpose : groups the program channel and the spike output channel of
//           spike_gen_array into one bundle.
// Signals : prog_gen_idx/prog_period/prog_ticks/prog_tag/prog_ct + prog_v/prog_a
//           (program write), out_tag/out_ct + out_v/out_a (emitted spike).
// Modports: slave  - the generator array (accepts programs, produces spikes)
//           master - the agent that programs generators and consumes spikes
// Handshake: a channel transfers on a rising clock edge where valid && ready
//           are both high. The valid side holds valid and its payload stable
//           until that edge; ready may rise or fall freely.
// -----------------------------------------------------------------------------
interface spike_gen_array_if #(
   parameter int NGENS_W = 3,
   parameter int NPERIOD = 16,
   parameter int NTAG    = 11,
   parameter int NCT     = 10
);
   logic [NGENS_W-1:0] prog_gen_idx;
   logic [NPERIOD-1:0] prog_period;
   logic [NPERIOD-1:0] prog_ticks;
   logic [NTAG-1:0]    prog_tag;
   logic [NCT-1:0]     prog_ct;
   logic               prog_v;
   logic               prog_a;
   logic [NTAG-1:0]    out_tag;
   logic [NCT-1:0]     out_ct;
   logic               out_v;
   logic               out_a;

   modport slave (
      input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_ct, prog_v,
      input  out_a,
      output prog_a,
      output out_tag, out_ct, out_v
   );

   modport master (
      output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_ct, prog_v,
      output out_a,
      input  prog_a,
      input  out_tag, out_ct, out_v
   );
endinterface

// File: rtl/spike_gen_array.sv
// -----------------------------------------------------------------------------
// spike_gen_array
// Purpose : NUM_GENS = 2**NGENS_W periodic spike generators sharing one output
//           channel. Each time_unit pulse triggers a scan over all generators
//           in index order; a generator whose countdown reaches zero emits its
//           (tag, ct) and reloads with period-1.
// Ports   : clk, reset_n (async, active-low)
//           time_unit   - one-cycle pulse per elapsed time unit
//           bus         - spike_gen_array_if.slave (program + output channels)
//           overrun_ct  - saturating count of dropped time_unit pulses
//           dbg_state_o - current FSM state (0 IDLE, 1 SCAN, 2 EMIT)
// -----------------------------------------------------------------------------
module spike_gen_array #(
   parameter int NGENS_W = 3,
   parameter int NPERIOD = 16,
   parameter int NTAG    = 11,
   parameter int NCT     = 10,
   parameter int NOVR    = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                time_unit,
   spike_gen_array_if.slave    bus,
   output logic [NOVR-1:0]     overrun_ct,
   output logic [1:0]          dbg_state_o
);

   localparam int NUM_GENS = 1 << NGENS_W;
   localparam logic [NGENS_W-1:0] LAST_IDX = {NGENS_W{1'b1}};
   localparam logic [NGENS_W-1:0] ONE_I    = {{(NGENS_W-1){1'b0}}, 1'b1};
   localparam logic [NPERIOD-1:0] ONE_P    = {{(NPERIOD-1){1'b0}}, 1'b1};
   localparam logic [NOVR-1:0]    ONE_O    = {{(NOVR-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [NGENS_W-1:0] idx_q, idx_d;
   logic               pending_q, pending_d;
   logic [NOVR-1:0]    ovr_q, ovr_d;
   // Holds prog_a low during reset and releases it on the first edge after.
   logic               alive_q;

   logic [NPERIOD-1:0] period_q [NUM_GENS];
   logic [NPERIOD-1:0] ticks_q  [NUM_GENS];
   logic [NTAG-1:0]    tag_q    [NUM_GENS];
   logic [NCT-1:0]     ct_q     [NUM_GENS];

   logic [NPERIOD-1:0] cur_period;
   logic [NPERIOD-1:0] cur_ticks;
   logic               gen_en;
   logic               fire;
   logic               last;
   logic               prog_a_int;
   logic               prog_we;
   logic               scan_end;

   assign cur_period = period_q[idx_q];
   assign cur_ticks  = ticks_q[idx_q];
   assign gen_en     = (cur_period != '0);
   assign fire       = gen_en && (cur_ticks == '0);
   assign last       = (idx_q == LAST_IDX);
   assign prog_we    = bus.prog_v && prog_a_int;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
         ovr_q     <= '0;
         alive_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         ovr_q     <= ovr_d;
         alive_q   <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      ovr_d     = ovr_q;
      scan_end  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (time_unit || pending_q) begin
               state_d   = S_SCAN;
               idx_d     = '0;
               // One trigger is consumed; a second one stays queued.
               pending_d = time_unit && pending_q;
            end
         end
         S_SCAN: begin
            if (fire) begin
               state_d = S_EMIT;
            end else if (last) begin
               scan_end = 1'b1;
            end else begin
               idx_d = idx_q + ONE_I;
            end
         end
         S_EMIT: begin
            if (bus.out_a) begin
               if (last) begin
                  scan_end = 1'b1;
               end else begin
                  state_d = S_SCAN;
                  idx_d   = idx_q + ONE_I;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase

      if (state_q != S_IDLE) begin
         if (scan_end) begin
            // A queued or coincident pulse restarts the scan without an IDLE
            // cycle, so programming cannot slip in between back-to-back scans.
            idx_d = '0;
            if (pending_q || time_unit) begin
               state_d   = S_SCAN;
               pending_d = pending_q && time_unit;
            end else begin
               state_d = S_IDLE;
            end
         end else if (time_unit) begin
            if (pending_q) begin
               if (ovr_q != {NOVR{1'b1}}) ovr_d = ovr_q + ONE_O;
            end else begin
               pending_d = 1'b1;
            end
         end
      end
   end

   // Outputs
   always_comb begin
      prog_a_int  = alive_q && (state_q == S_IDLE);
      bus.prog_a  = prog_a_int;
      bus.out_v   = (state_q == S_EMIT);
      bus.out_tag = tag_q[idx_q];
      bus.out_ct  = ct_q[idx_q];
      overrun_ct  = ovr_q;
      dbg_state_o = state_q;
   end

   // Generator table. Programming only happens in IDLE and countdown updates
   // only in SCAN, so the two writers never collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int g = 0; g < NUM_GENS; g++) begin
            period_q[g] <= '0;
            ticks_q[g]  <= '0;
            tag_q[g]    <= '0;
            ct_q[g]     <= '0;
         end
      end else begin
         if (prog_we) begin
            period_q[bus.prog_gen_idx] <= bus.prog_period;
            ticks_q[bus.prog_gen_idx]  <= bus.prog_ticks;
            tag_q[bus.prog_gen_idx]    <= bus.prog_tag;
            ct_q[bus.prog_gen_idx]     <= bus.prog_ct;
         end
         if ((state_q == S_SCAN) && gen_en) begin
            ticks_q[idx_q] <= fire ? (cur_period - ONE_P) : (cur_ticks - ONE_P);
         end
      end
   end

endmodule

// File: tb/tb_spike_gen_array.sv
module tb_spike_gen_array;

   localparam int NUM_GENS = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       time_unit;
   logic [7:0] overrun_ct;
   logic [1:0] dbg_state;

   logic [20:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   spike_gen_array_if #(.NGENS_W(3), .NPERIOD(16), .NTAG(11), .NCT(10)) bus ();

   spike_gen_array #(
      .NGENS_W(3), .NPERIOD(16), .NTAG(11), .NCT(10), .NOVR(8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .time_unit   (time_unit),
      .bus         (bus),
      .overrun_ct  (overrun_ct),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [20:0] mk(input logic [10:0] t, input logic [9:0] c);
      return {t, c};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      time_unit = 1'b1;
      tick();
      time_unit = 1'b0;
   endtask

   task automatic prog(input int g, input int per, input int tk, input int tag, input int ct);
      bit done;
      done = 1'b0;
      bus.prog_gen_idx = 3'(g);
      bus.prog_period  = 16'(per);
      bus.prog_ticks   = 16'(tk);
      bus.prog_tag     = 11'(tag);
      bus.prog_ct      = 10'(ct);
      bus.prog_v       = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (bus.prog_a) done = 1'b1;
         tick();
      end
      bus.prog_v = 1'b0;
      chk("prog_done", 32'(done), 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (dbg_state != 2'd0 && n < 500) begin
         tick();
         n++;
      end
      chk("idle_reached", 32'(dbg_state), 32'd0);
   endtask

   task automatic wait_outv(output int n);
      n = 0;
      while (!bus.out_v && n < 100) begin
         tick();
         n++;
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      forever begin
         logic [20:0] e;
         @(negedge clk);
         if (reset_n && bus.out_v && bus.out_a) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spike_unexpected act=%0h exp=none", {bus.out_tag, bus.out_ct});
            end else begin
               e = exp_q.pop_front();
               chk("spike", 32'({bus.out_tag, bus.out_ct}), 32'(e));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      reset_n          = 1'b0;
      time_unit        = 1'b0;
      bus.prog_gen_idx = '0;
      bus.prog_period  = '0;
      bus.prog_ticks   = '0;
      bus.prog_tag     = '0;
      bus.prog_ct      = '0;
      bus.prog_v       = 1'b0;
      bus.out_a        = 1'b0;

      // Reset state
      #2;
      chk("rst_prog_a", 32'(bus.prog_a), 32'd0);
      chk("rst_out_v", 32'(bus.out_v), 32'd0);
      chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
      chk("rst_out_ct", 32'(bus.out_ct), 32'd0);
      chk("rst_overrun", 32'(overrun_ct), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #4 reset_n = 1'b1;
      #1;
      chk("prog_a_before_edge", 32'(bus.prog_a), 32'd0);
      tick();
      chk("prog_a_after_edge", 32'(bus.prog_a), 32'd1);

      // Gen 2: period 3, phase 0 -> spikes on pulses 1 and 4 of 6
      bus.out_a = 1'b1;
      prog(2, 3, 0, 'h15, 1);
      exp_q.push_back(mk(11'h15, 10'd1));
      pulse();
      wait_outv(n);
      chk("lat_gen2", 32'(n), 32'd3);
      wait_idle();
      for (int p = 2; p <= 6; p++) begin
         if (p == 4) exp_q.push_back(mk(11'h15, 10'd1));
         pulse();
         wait_idle();
      end
      chk("q_after_gen2", 32'(exp_q.size()), 32'd0);

      // Disable gen 2 (it would fire on the next pulse otherwise)
      prog(2, 0, 0, 'h15, 1);
      for (int p = 0; p < 3; p++) begin
         pulse();
         wait_idle();
      end

      // Gens 0 and 5, period 1; stall the output and pulse 3 more times
      prog(0, 1, 0, 'h0A0, 3);
      prog(5, 1, 0, 'h055, 7);
      bus.out_a = 1'b0;
      exp_q.push_back(mk(11'h0A0, 10'd3));
      exp_q.push_back(mk(11'h055, 10'd7));
      pulse();
      wait_outv(n);
      chk("lat_gen0", 32'(n), 32'd1);
      exp_q.push_back(mk(11'h0A0, 10'd3));
      exp_q.push_back(mk(11'h055, 10'd7));
      for (int i = 0; i < 10; i++) begin
         if (i == 2 || i == 4 || i == 6) pulse();
         else tick();
         chk("stall_out_v", 32'(bus.out_v), 32'd1);
         chk("stall_tag", 32'(bus.out_tag), 32'h0A0);
         chk("stall_ct", 32'(bus.out_ct), 32'd3);
      end
      chk("overrun_2", 32'(overrun_ct), 32'd2);
      bus.out_a = 1'b1;
      wait_idle();
      chk("q_after_stall", 32'(exp_q.size()), 32'd0);
      chk("overrun_kept", 32'(overrun_ct), 32'd2);

      // Program request during SCAN waits for IDLE
      exp_q.push_back(mk(11'h0A0, 10'd3));
      exp_q.push_back(mk(11'h055, 10'd7));
      pulse();
      chk("scan_state", 32'(dbg_state), 32'd1);
      bus.prog_gen_idx = 3'd3;
      bus.prog_period  = 16'd2;
      bus.prog_ticks   = 16'd1;
      bus.prog_tag     = 11'h333;
      bus.prog_ct      = 10'h033;
      bus.prog_v       = 1'b1;
      #0;
      chk("prog_a_in_scan", 32'(bus.prog_a), 32'd0);
      n = 0;
      while (!bus.prog_a && n < 100) begin
         tick();
         n++;
      end
      chk("prog_wait_cycles", 32'(n), 32'd10);
      tick();
      bus.prog_v = 1'b0;
      chk("prog_a_after_write", 32'(bus.prog_a), 32'd1);
      chk("state_after_write", 32'(dbg_state), 32'd0);

      // Gen 3 counts 1 -> 0 on this pulse, fires on the next one
      exp_q.push_back(mk(11'h0A0, 10'd3));
      exp_q.push_back(mk(11'h055, 10'd7));
      pulse();
      wait_idle();

      // Program gen 6 on the same cycle as a pulse: scan sees the new values
      exp_q.push_back(mk(11'h0A0, 10'd3));
      exp_q.push_back(mk(11'h333, 10'h033));
      exp_q.push_back(mk(11'h055, 10'd7));
      exp_q.push_back(mk(11'h666, 10'h066));
      bus.prog_gen_idx = 3'd6;
      bus.prog_period  = 16'd1;
      bus.prog_ticks   = 16'd0;
      bus.prog_tag     = 11'h666;
      bus.prog_ct      = 10'h066;
      bus.prog_v       = 1'b1;
      time_unit        = 1'b1;
      tick();
      bus.prog_v = 1'b0;
      time_unit  = 1'b0;
      wait_idle();
      chk("q_after_coincide", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a stalled EMIT
      bus.out_a = 1'b0;
      pulse();
      wait_outv(n);
      chk("emit_before_rst", 32'(bus.out_v), 32'd1);
      #3 reset_n = 1'b0;
      #1;
      chk("rst_mid_out_v", 32'(bus.out_v), 32'd0);
      chk("rst_mid_prog_a", 32'(bus.prog_a), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #4 reset_n = 1'b1;
      #1;
      chk("rel_prog_a_low", 32'(bus.prog_a), 32'd0);
      tick();
      chk("rel_prog_a_high", 32'(bus.prog_a), 32'd1);
      chk("rel_overrun", 32'(overrun_ct), 32'd0);
      bus.out_a = 1'b1;
      pulse();
      n = 0;
      while (dbg_state != 2'd0 && n < 100) begin
         tick();
         n++;
      end
      chk("empty_scan_len", 32'(n), 32'(NUM_GENS));
      tick();
      chk("q_final", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
